// File: rtl/cpu_pkg.sv
// Shared types and instruction-field positions for the 8-bit CPU control path.
// The field positions assume the 16-bit instruction format.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_LDI  = 4'h6,
      OP_JMP  = 4'h7,
      OP_BZ   = 4'h8,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD    = 3'd0,
      ALU_SUB    = 3'd1,
      ALU_AND    = 3'd2,
      ALU_OR     = 3'd3,
      ALU_XOR    = 3'd4,
      ALU_PASS_B = 3'd5
   } alu_op_e;

   // Sequencer states, kept as plain constants of a 2-bit type.
   typedef logic [1:0] state_e;
   localparam state_e FETCH  = 2'd0;
   localparam state_e DECODE = 2'd1;
   localparam state_e EXEC   = 2'd2;
   localparam state_e HALTED = 2'd3;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

endpackage

// File: rtl/instr_decode.sv
// Pure combinational instruction decoder: turns the latched instruction word into
// register-file addresses, ALU controls and control-flow flags.
module instr_decode
   import cpu_pkg::*;
#(
   parameter int IW = 16,
   parameter int DW = 8
) (
   input  logic [IW-1:0] ir_i,
   output logic [3:0]    ra1_o,
   output logic [3:0]    ra2_o,
   output logic [3:0]    wa_o,
   output logic [2:0]    alu_op_o,
   output logic [DW-1:0] imm_o,
   output logic          use_imm_o,
   output logic          we_o,
   output logic          is_jmp_o,
   output logic          is_bz_o,
   output logic          is_halt_o,
   output logic          is_illegal_o
);

   logic [3:0] op;

   always_comb begin
      op           = ir_i[OP_MSB:OP_LSB];
      ra1_o        = ir_i[RS1_MSB:RS1_LSB];
      ra2_o        = ir_i[RS2_MSB:RS2_LSB];
      wa_o         = ir_i[RD_MSB:RD_LSB];
      imm_o        = ir_i[IMM_MSB:IMM_LSB];
      alu_op_o     = ALU_ADD;
      use_imm_o    = 1'b0;
      we_o         = 1'b0;
      is_jmp_o     = 1'b0;
      is_bz_o      = 1'b0;
      is_halt_o    = 1'b0;
      is_illegal_o = 1'b0;
      case (op)
         OP_NOP: ;
         OP_ADD: begin alu_op_o = ALU_ADD; we_o = 1'b1; end
         OP_SUB: begin alu_op_o = ALU_SUB; we_o = 1'b1; end
         OP_AND: begin alu_op_o = ALU_AND; we_o = 1'b1; end
         OP_OR:  begin alu_op_o = ALU_OR;  we_o = 1'b1; end
         OP_XOR: begin alu_op_o = ALU_XOR; we_o = 1'b1; end
         OP_LDI: begin
            alu_op_o  = ALU_PASS_B;
            use_imm_o = 1'b1;
            we_o      = 1'b1;
         end
         OP_JMP:  is_jmp_o = 1'b1;
         // BZ tests the register named in the rd field, so route it to read port 1
         OP_BZ: begin
            ra1_o   = ir_i[RD_MSB:RD_LSB];
            is_bz_o = 1'b1;
         end
         OP_HALT: is_halt_o = 1'b1;
         default: is_illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer: owns pc, instruction register,
// HALT and illegal-opcode status, and drives the register-file control ports.
module fetch_decode_ctrl
   import cpu_pkg::*;
#(
   parameter int PC_W = 8,
   parameter int IW   = 16,
   parameter int DW   = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [IW-1:0]   imem_rdata,
   input  logic [DW-1:0]   RD1,
   output logic [3:0]      RA1,
   output logic [3:0]      RA2,
   output logic [3:0]      WA,
   output logic            write_enable,
   output logic [2:0]      alu_op,
   output logic [DW-1:0]   imm,
   output logic            use_imm,
   output logic            halted,
   output logic            illegal
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic            halted_q, halted_d;
   logic            illegal_q, illegal_d;
   logic            run_q;

   logic dec_we, dec_is_jmp, dec_is_bz, dec_is_halt, dec_is_illegal;
   logic branch_taken;

   instr_decode #(.IW(IW), .DW(DW)) u_decode (
      .ir_i         (ir_q),
      .ra1_o        (RA1),
      .ra2_o        (RA2),
      .wa_o         (WA),
      .alu_op_o     (alu_op),
      .imm_o        (imm),
      .use_imm_o    (use_imm),
      .we_o         (dec_we),
      .is_jmp_o     (dec_is_jmp),
      .is_bz_o      (dec_is_bz),
      .is_halt_o    (dec_is_halt),
      .is_illegal_o (dec_is_illegal)
   );

   assign branch_taken = dec_is_jmp || (dec_is_bz && (RD1 == '0));

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      case (state_q)
         FETCH: begin
            if (run_q && imem_valid) begin
               ir_d    = imem_rdata;
               state_d = DECODE;
            end
         end
         DECODE: state_d = EXEC;
         EXEC: begin
            if (dec_is_illegal) illegal_d = 1'b1;
            if (dec_is_halt) begin
               halted_d = 1'b1;
               state_d  = HALTED;
            end else begin
               pc_d    = branch_taken ? imm[PC_W-1:0] : pc_q + PC_W'(1);
               state_d = FETCH;
            end
         end
         HALTED: ;
         default: state_d = FETCH;
      endcase
   end

   // run_q holds off the first request until one clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         pc_q      <= '0;
         ir_q      <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         run_q     <= 1'b1;
      end
   end

   assign imem_req     = (state_q == FETCH) && run_q;
   assign imem_addr    = pc_q;
   assign write_enable = (state_q == EXEC) && dec_we;
   assign halted       = halted_q;
   assign illegal      = illegal_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: a small register-file/ALU datapath plus an
// instruction-level reference interpreter that predicts pc, writes and status.
module tb_fetch_decode_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_valid;
   logic [15:0] imem_rdata;
   logic [7:0]  rd1;
   logic [3:0]  ra1, ra2, wa;
   logic        write_enable;
   logic [2:0]  alu_op;
   logic [7:0]  imm;
   logic        use_imm;
   logic        halted;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   logic [15:0] prog [256];
   logic [7:0]  dp_rf [16] = '{default: 8'h00};
   logic [7:0]  m_rf [16];
   logic [7:0]  m_pc;
   logic        m_halt, m_ill;
   logic [7:0]  rd2, opb, alu_res;

   fetch_decode_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_valid   (imem_valid),
      .imem_rdata   (imem_rdata),
      .RD1          (rd1),
      .RA1          (ra1),
      .RA2          (ra2),
      .WA           (wa),
      .write_enable (write_enable),
      .alu_op       (alu_op),
      .imm          (imm),
      .use_imm      (use_imm),
      .halted       (halted),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   // Register file and ALU the controller steers; r0 reads as zero
   assign rd1 = (ra1 == 4'd0) ? 8'h00 : dp_rf[ra1];
   assign rd2 = (ra2 == 4'd0) ? 8'h00 : dp_rf[ra2];
   assign opb = use_imm ? imm : rd2;
   always_comb begin
      alu_res = 8'h00;
      case (alu_op)
         3'd0: alu_res = rd1 + opb;
         3'd1: alu_res = rd1 - opb;
         3'd2: alu_res = rd1 & opb;
         3'd3: alu_res = rd1 | opb;
         3'd4: alu_res = rd1 ^ opb;
         3'd5: alu_res = opb;
         default: alu_res = 8'h00;
      endcase
   end
   always @(posedge clk) begin
      if (write_enable && wa != 4'd0) dp_rf[wa] <= alu_res;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered on a negedge; leaves the DUT in FETCH one clock after release
   task automatic do_reset();
      rst_n      = 1'b0;
      imem_valid = 1'b0;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_we", write_enable, 0);
      @(negedge clk);
      chk("rst_fields", {ra1, ra2, wa, alu_op, imm, use_imm}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_req", imem_req, 1);
      chk("rel_addr", imem_addr, 0);
      m_pc   = 8'h00;
      m_halt = 1'b0;
      m_ill  = 1'b0;
   endtask

   // One instruction at the instruction-set level, with 'waits' memory wait cycles
   task automatic step(input int waits);
      logic [15:0] ins;
      logic [3:0]  op, rd, rs1, rs2;
      logic [7:0]  im, a, b;
      logic        exp_we;
      ins = prog[m_pc];
      op  = ins[15:12];
      rd  = ins[11:8];
      rs1 = ins[7:4];
      rs2 = ins[3:0];
      im  = ins[7:0];
      for (int w = 0; w < waits; w++) begin
         chk("wait_req", imem_req, 1);
         chk("wait_addr", imem_addr, m_pc);
         chk("wait_we", write_enable, 0);
         @(negedge clk);
      end
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      imem_valid = 1'b1;
      imem_rdata = ins;
      @(negedge clk);
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      exp_we = (op >= 4'd1) && (op <= 4'd6);
      chk("dec_req", imem_req, 0);
      chk("dec_we", write_enable, 0);
      if (exp_we) begin
         chk("dec_wa", wa, rd);
         chk("dec_aluop", alu_op, (op == 4'd6) ? 3'd5 : 3'(op - 4'd1));
         chk("dec_useimm", use_imm, (op == 4'd6) ? 1 : 0);
      end
      if (op == 4'd6) chk("dec_imm", imm, im);
      if (op >= 4'd1 && op <= 4'd5) chk("dec_ra", {ra1, ra2}, {rs1, rs2});
      if (op == 4'd8) chk("dec_bz_ra1", ra1, rd);
      @(negedge clk);
      imem_valid = 1'($urandom_range(0, 1));
      chk("exec_we", write_enable, exp_we);
      chk("exec_req", imem_req, 0);
      a = m_rf[rs1];
      b = m_rf[rs2];
      case (op)
         4'h1: m_rf[rd] = a + b;
         4'h2: m_rf[rd] = a - b;
         4'h3: m_rf[rd] = a & b;
         4'h4: m_rf[rd] = a | b;
         4'h5: m_rf[rd] = a ^ b;
         4'h6: m_rf[rd] = im;
         default: ;
      endcase
      m_rf[0] = 8'h00;
      if (op == 4'h7) m_pc = im;
      else if (op == 4'h8) m_pc = (m_rf[rd] == 8'h00) ? im : m_pc + 8'd1;
      else if (op == 4'hF) m_halt = 1'b1;
      else m_pc = m_pc + 8'd1;
      if (op >= 4'h9 && op <= 4'hE) m_ill = 1'b1;
      @(negedge clk);
      imem_valid = 1'b0;
      chk("post_we", write_enable, 0);
      chk("post_addr", imem_addr, m_pc);
      chk("post_halted", halted, m_halt);
      chk("post_illegal", illegal, m_ill);
   endtask

   initial begin
      rst_n      = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = 16'h0000;
      for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
      @(negedge clk);
      do_reset();

      // LDI, ADD with a 5-cycle wait, BZ taken/not taken, JMP to FF and wrap
      prog[8'h00] = 16'h632A;
      prog[8'h01] = 16'h1F33;
      prog[8'h02] = 16'h8010;
      prog[8'h10] = 16'h8310;
      prog[8'h11] = 16'h70FF;
      prog[8'hFF] = 16'h0000;
      step(0);
      step(5);
      chk("r3_value", dp_rf[3], 8'h2A);
      chk("r15_value", dp_rf[15], 8'h54);
      step(1);
      chk("bz_taken_pc", imem_addr, 8'h10);
      step(0);
      chk("bz_not_taken_pc", imem_addr, 8'h11);
      step(2);
      chk("jmp_pc", imem_addr, 8'hFF);
      step(0);
      chk("wrap_pc", imem_addr, 8'h00);
      step(0);

      // Reset while waiting on a fetch at pc=1
      @(negedge clk);
      chk("midfetch_req", imem_req, 1);
      chk("midfetch_addr", imem_addr, 8'h01);
      do_reset();

      // Illegal opcode then normal execution
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
      prog[0] = 16'hA123;
      prog[1] = 16'h6105;
      prog[2] = 16'h5213;
      prog[3] = 16'h2421;
      step(1);
      chk("illegal_set", illegal, 1);
      step(0);
      step(0);
      step(3);
      chk("illegal_sticky", illegal, 1);

      // Random programs over the whole address space
      for (int i = 0; i < 256; i++) begin
         logic [3:0] rop;
         rop = 4'($urandom_range(0, 8));
         if ($urandom_range(0, 19) == 0) rop = 4'($urandom_range(9, 14));
         prog[i] = {rop, 12'($urandom)};
      end
      for (int n = 0; n < 80; n++) step($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) chk("rf_compare", dp_rf[i], m_rf[i]);

      // HALT at pc=5
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
      prog[0] = 16'h6C11;
      prog[1] = 16'h1DCC;
      prog[2] = 16'h9000;
      prog[3] = 16'h3EDC;
      prog[4] = 16'h0000;
      prog[5] = 16'hF000;
      for (int n = 0; n < 6; n++) step(n % 3);
      for (int c = 0; c < 20; c++) begin
         imem_valid = 1'($urandom_range(0, 1));
         chk("halt_req", imem_req, 0);
         chk("halt_we", write_enable, 0);
         chk("halt_flag", halted, 1);
         chk("halt_pc", imem_addr, 8'h05);
         @(negedge clk);
      end
      for (int i = 0; i < 16; i++) chk("rf_halt", dp_rf[i], m_rf[i]);
      do_reset();
      chk("after_halt_rst", halted, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
